// File: rtl/cpu_memory.sv
// Memory-access stage: pass-through, aligned bus loads/stores, load extension.
// CPU_MEMORY_UNALIGNED_EN splits crossing accesses into two bus cycles.
module cpu_memory (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_tag,
    input  logic [4:0]  i_inst_rd,
    input  logic [4:0]  i_mem_inst_rd,
    input  logic [31:0] i_rd,
    input  logic        i_branch,
    input  logic [31:0] i_pc_next,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_mem_width,
    input  logic        i_mem_signed,
    input  logic [31:0] i_mem_address,
    output logic [7:0]  o_tag,
    output logic [4:0]  o_inst_rd,
    output logic [31:0] o_rd,
    output logic        o_branch,
    output logic [31:0] o_pc_next,
    output logic        o_fault,
    output logic        o_busy,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [3:0]  o_bus_wmask,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ACCESS    = 2'd1;
`ifdef CPU_MEMORY_UNALIGNED_EN
    localparam logic [1:0] S_ACCESS_HI = 2'd2;
`endif

    logic [1:0]  r_state;
    logic [7:0]  r_tag;
    logic [4:0]  r_inst_rd;
    logic [31:0] r_rd;
    logic        r_branch;
    logic [31:0] r_pc_next;
    logic        r_fault;
    logic        r_req;
    logic        r_rw;
    logic [31:0] r_addr;
    logic [3:0]  r_wmask;
    logic [31:0] r_wdata;

    logic [7:0]  r_l_tag;
    logic [4:0]  r_l_mem_rd;
    logic        r_l_branch;
    logic [31:0] r_l_pc;
    logic        r_l_write;
    logic [2:0]  r_l_width;
    logic        r_l_signed;
    logic [1:0]  r_l_off;
`ifdef CPU_MEMORY_UNALIGNED_EN
    logic        r_l_cross;
    logic [31:0] r_l_data;
    logic [31:0] r_lo_word;
`endif

    logic        w_new;
    logic        w_mem;
    logic [1:0]  w_off;
    logic        w_cross;
    logic [3:0]  w_st_mask;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_shift;
    logic [31:0] w_ld_align;
    logic [31:0] w_ld_ext;
    logic        w_done;

    assign w_new   = (i_tag != r_tag);
    assign w_mem   = i_mem_read | i_mem_write;
    assign w_off   = i_mem_address[1:0];
    assign w_cross = ((i_mem_width == 3'd4) && (w_off != 2'd0)) ||
                     ((i_mem_width == 3'd2) && (w_off == 2'd3));

    always_comb begin
        w_st_mask = 4'b1111;
        w_st_data = i_rd;
        case (i_mem_width)
            3'd1: begin
                w_st_mask = 4'b0001 << w_off;
                w_st_data = {4{i_rd[7:0]}};
            end
            3'd2: begin
                w_st_mask = 4'b0011 << w_off;
                w_st_data = {2{i_rd[15:0]}};
            end
            default: begin
                w_st_mask = 4'b1111;
                w_st_data = i_rd;
            end
        endcase
`ifdef CPU_MEMORY_UNALIGNED_EN
        if (w_cross) begin
            w_st_mask = 4'b1111 << w_off;
            w_st_data = i_rd << {w_off, 3'b000};
        end
`endif
    end

    assign w_ld_shift = i_bus_rdata >> {r_l_off, 3'b000};

`ifdef CPU_MEMORY_UNALIGNED_EN
    logic [63:0] w_ld_comb;
    logic [2:0]  w_hi_n;
    logic [3:0]  w_hi_mask;
    logic [31:0] w_hi_data;

    assign w_ld_comb  = {i_bus_rdata, r_lo_word} >> {r_l_off, 3'b000};
    assign w_ld_align = (r_state == S_ACCESS_HI) ? w_ld_comb[31:0]
                                                 : w_ld_shift;
    assign w_hi_n     = 3'd4 - {1'b0, r_l_off};
    assign w_hi_mask  = 4'b1111 >> w_hi_n;
    assign w_hi_data  = r_l_data >> {w_hi_n, 3'b000};
    assign w_done     = i_bus_ready &&
                        (((r_state == S_ACCESS) && !r_l_cross) ||
                         ((r_state == S_ACCESS_HI) && r_req));
`else
    assign w_ld_align = w_ld_shift;
    assign w_done     = i_bus_ready && (r_state == S_ACCESS);
`endif

    always_comb begin
        w_ld_ext = w_ld_align;
        case (r_l_width)
            3'd1: w_ld_ext = {{24{r_l_signed & w_ld_align[7]}},
                              w_ld_align[7:0]};
            3'd2: w_ld_ext = {{16{r_l_signed & w_ld_align[15]}},
                              w_ld_align[15:0]};
            default: w_ld_ext = w_ld_align;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_tag      <= '0;
            r_inst_rd  <= '0;
            r_rd       <= '0;
            r_branch   <= 1'b0;
            r_pc_next  <= '0;
            r_fault    <= 1'b0;
            r_req      <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wmask    <= '0;
            r_wdata    <= '0;
            r_l_tag    <= '0;
            r_l_mem_rd <= '0;
            r_l_branch <= 1'b0;
            r_l_pc     <= '0;
            r_l_write  <= 1'b0;
            r_l_width  <= '0;
            r_l_signed <= 1'b0;
            r_l_off    <= '0;
`ifdef CPU_MEMORY_UNALIGNED_EN
            r_l_cross  <= 1'b0;
            r_l_data   <= '0;
            r_lo_word  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_new) begin
                        r_l_tag    <= i_tag;
                        r_l_mem_rd <= i_mem_inst_rd;
                        r_l_branch <= i_branch;
                        r_l_pc     <= i_pc_next;
                        r_l_write  <= i_mem_write;
                        r_l_width  <= i_mem_width;
                        r_l_signed <= i_mem_signed;
                        r_l_off    <= w_off;
`ifdef CPU_MEMORY_UNALIGNED_EN
                        r_l_cross  <= w_cross;
                        r_l_data   <= i_rd;
`endif
                        if (!w_mem) begin
                            r_tag     <= i_tag;
                            r_inst_rd <= i_inst_rd;
                            r_rd      <= i_rd;
                            r_branch  <= i_branch;
                            r_pc_next <= i_pc_next;
                            r_fault   <= 1'b0;
`ifndef CPU_MEMORY_UNALIGNED_EN
                        end else if (w_cross) begin
                            // Misaligned: retire at once, no bus cycle
                            r_tag     <= i_tag;
                            r_inst_rd <= '0;
                            r_branch  <= i_branch;
                            r_pc_next <= i_pc_next;
                            r_fault   <= 1'b1;
`endif
                        end else begin
                            r_state <= S_ACCESS;
                            r_req   <= 1'b1;
                            r_rw    <= i_mem_write;
                            r_addr  <= {i_mem_address[31:2], 2'b00};
                            r_wmask <= i_mem_write ? w_st_mask : 4'b0000;
                            r_wdata <= w_st_data;
                        end
                    end
                end
                S_ACCESS: begin
`ifdef CPU_MEMORY_UNALIGNED_EN
                    if (i_bus_ready && r_l_cross) begin
                        r_req     <= 1'b0;
                        r_lo_word <= i_bus_rdata;
                        r_state   <= S_ACCESS_HI;
                    end
`endif
                end
`ifdef CPU_MEMORY_UNALIGNED_EN
                S_ACCESS_HI: begin
                    // One idle cycle separates the two halves
                    if (!r_req) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_addr + 32'd4;
                        r_wmask <= r_rw ? w_hi_mask : 4'b0000;
                        r_wdata <= w_hi_data;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase

            if (w_done) begin
                r_state   <= S_IDLE;
                r_req     <= 1'b0;
                r_tag     <= r_l_tag;
                r_branch  <= r_l_branch;
                r_pc_next <= r_l_pc;
                r_fault   <= 1'b0;
                if (r_l_write) begin
                    r_inst_rd <= '0;
                end else begin
                    r_inst_rd <= r_l_mem_rd;
                    r_rd      <= w_ld_ext;
                end
            end
        end
    end

    assign o_tag         = r_tag;
    assign o_inst_rd     = r_inst_rd;
    assign o_rd          = r_rd;
    assign o_branch      = r_branch;
    assign o_pc_next     = r_pc_next;
    assign o_fault       = r_fault;
    assign o_busy        = (r_state != S_IDLE);
    assign o_bus_request = r_req;
    assign o_bus_rw      = r_rw;
    assign o_bus_address = r_addr;
    assign o_bus_wmask   = r_wmask;
    assign o_bus_wdata   = r_wdata;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory: pass-through, loads, stores,
// misaligned handling, busy hold-off and reset during an access.
module tb_cpu_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_tag;
    logic [4:0]  i_inst_rd;
    logic [4:0]  i_mem_inst_rd;
    logic [31:0] i_rd;
    logic        i_branch;
    logic [31:0] i_pc_next;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_mem_width;
    logic        i_mem_signed;
    logic [31:0] i_mem_address;
    logic [7:0]  o_tag;
    logic [4:0]  o_inst_rd;
    logic [31:0] o_rd;
    logic        o_branch;
    logic [31:0] o_pc_next;
    logic        o_fault;
    logic        o_busy;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [3:0]  o_bus_wmask;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic        cap_req;
    logic        cap_rw;
    logic [31:0] cap_addr;
    logic [3:0]  cap_mask;
    logic [31:0] cap_wdata;
    int          busy_n;

    always #5 clk = ~clk;

    cpu_memory dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_tag         (i_tag),
        .i_inst_rd     (i_inst_rd),
        .i_mem_inst_rd (i_mem_inst_rd),
        .i_rd          (i_rd),
        .i_branch      (i_branch),
        .i_pc_next     (i_pc_next),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_mem_width   (i_mem_width),
        .i_mem_signed  (i_mem_signed),
        .i_mem_address (i_mem_address),
        .o_tag         (o_tag),
        .o_inst_rd     (o_inst_rd),
        .o_rd          (o_rd),
        .o_branch      (o_branch),
        .o_pc_next     (o_pc_next),
        .o_fault       (o_fault),
        .o_busy        (o_busy),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wmask   (o_bus_wmask),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ready   (i_bus_ready),
        .i_bus_rdata   (i_bus_rdata)
    );

    task automatic drive_pass(input logic [7:0] tag, input logic [31:0] rd,
                              input logic [4:0] ird);
        i_tag       = tag;
        i_rd        = rd;
        i_inst_rd   = ird;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
    endtask

    // Issue one access at a negedge, ready after 'waits' idle cycles
    task automatic run_access(input logic [7:0] tag, input logic wr,
                              input logic [2:0] w, input logic sg,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] mrd, input int waits,
                              input logic [31:0] rdata);
        i_tag         = tag;
        i_mem_read    = ~wr;
        i_mem_write   = wr;
        i_mem_width   = w;
        i_mem_signed  = sg;
        i_mem_address = addr;
        i_rd          = data;
        i_mem_inst_rd = mrd;
        @(negedge clk);
        cap_req   = o_bus_request;
        cap_rw    = o_bus_rw;
        cap_addr  = o_bus_address;
        cap_mask  = o_bus_wmask;
        cap_wdata = o_bus_wdata;
        busy_n    = 0;
        for (int i = 0; i <= waits; i++) begin
            if (o_busy) busy_n++;
            if (i == waits) begin
                i_bus_ready = 1'b1;
                i_bus_rdata = rdata;
            end
            @(negedge clk);
        end
        i_bus_ready = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (o_tag !== 8'h00) begin
            n_fail++; $display("FAIL rst_tag got %h exp %h", o_tag, 8'h00);
        end
        n_checks++;
        if ({o_busy, o_bus_request, o_fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_flags got %b exp %b",
                     {o_busy, o_bus_request, o_fault}, 3'b000);
        end
        n_checks++;
        if (o_rd !== 32'h0 || o_bus_wmask !== 4'h0 || o_inst_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_data got %h/%h/%h exp 0",
                     o_rd, o_bus_wmask, o_inst_rd);
        end
    endtask

    task automatic test_pass_through;
        drive_pass(8'h01, 32'h1, 5'd1);
        i_branch  = 1'b1;
        i_pc_next = 32'h0000_0400;
        @(negedge clk);
        drive_pass(8'h02, 32'h1234, 5'd5);
        @(negedge clk);
        n_checks++;
        if (o_rd !== 32'h1234 || o_inst_rd !== 5'd5 || o_tag !== 8'h02) begin
            n_fail++;
            $display("FAIL pt_out got %h/%0d/%h exp 1234/5/02",
                     o_rd, o_inst_rd, o_tag);
        end
        n_checks++;
        if (o_bus_request !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pt_req got %b/%b exp 0/0", o_bus_request, o_busy);
        end
        n_checks++;
        if (o_branch !== 1'b1 || o_pc_next !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL pt_pc got %b/%h exp 1/00000400", o_branch, o_pc_next);
        end
        i_branch    = 1'b0;
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        i_bus_ready = 1'b0;
        n_checks++;
        if (o_rd !== 32'h1234 || o_tag !== 8'h02 || o_bus_request !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready got %h/%h/%b exp 1234/02/0",
                     o_rd, o_tag, o_bus_request);
        end
    endtask

    task automatic test_loads;
        run_access(8'h03, 1'b0, 3'd1, 1'b1, 32'h1003, 32'h0, 5'd7,
                   3, 32'h80FF_FFFF);
        n_checks++;
        if (cap_req !== 1'b1 || cap_rw !== 1'b0 || cap_addr !== 32'h1000) begin
            n_fail++;
            $display("FAIL lb_bus got %b/%b/%h exp 1/0/00001000",
                     cap_req, cap_rw, cap_addr);
        end
        n_checks++;
        if (busy_n !== 4 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_busy got %0d/%b exp 4/0", busy_n, o_busy);
        end
        n_checks++;
        if (o_rd !== 32'hFFFF_FF80 || o_inst_rd !== 5'd7 || o_tag !== 8'h03) begin
            n_fail++;
            $display("FAIL lb_res got %h/%0d/%h exp ffffff80/7/03",
                     o_rd, o_inst_rd, o_tag);
        end
        n_checks++;
        if (o_bus_request !== 1'b0) begin
            n_fail++; $display("FAIL lb_drop got %b exp 0", o_bus_request);
        end
        run_access(8'h04, 1'b0, 3'd1, 1'b0, 32'h1001, 32'h0, 5'd8,
                   0, 32'h1234_80FF);
        n_checks++;
        if (o_rd !== 32'h0000_0080 || o_inst_rd !== 5'd8) begin
            n_fail++;
            $display("FAIL lbu got %h/%0d exp 00000080/8", o_rd, o_inst_rd);
        end
        run_access(8'h05, 1'b0, 3'd2, 1'b1, 32'h1002, 32'h0, 5'd9,
                   1, 32'h9ABC_0000);
        n_checks++;
        if (o_rd !== 32'hFFFF_9ABC || busy_n !== 2) begin
            n_fail++;
            $display("FAIL lh got %h/%0d exp ffff9abc/2", o_rd, busy_n);
        end
        run_access(8'h06, 1'b0, 3'd4, 1'b1, 32'h1004, 32'h0, 5'd10,
                   0, 32'h8000_0001);
        n_checks++;
        if (o_rd !== 32'h8000_0001 || cap_addr !== 32'h1004) begin
            n_fail++;
            $display("FAIL lw got %h/%h exp 80000001/00001004", o_rd, cap_addr);
        end
    endtask

    task automatic test_stores;
        run_access(8'h07, 1'b1, 3'd2, 1'b0, 32'h2002, 32'h0000_ABCD, 5'd9,
                   0, 32'h0);
        n_checks++;
        if (cap_addr !== 32'h2000 || cap_rw !== 1'b1 || cap_mask !== 4'b1100) begin
            n_fail++;
            $display("FAIL sh_bus got %h/%b/%b exp 00002000/1/1100",
                     cap_addr, cap_rw, cap_mask);
        end
        n_checks++;
        if (cap_wdata !== 32'hABCD_ABCD) begin
            n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", cap_wdata);
        end
        n_checks++;
        if (o_inst_rd !== 5'd0 || o_rd !== 32'h8000_0001 || o_tag !== 8'h07) begin
            n_fail++;
            $display("FAIL sh_res got %0d/%h/%h exp 0/80000001/07",
                     o_inst_rd, o_rd, o_tag);
        end
        run_access(8'h08, 1'b1, 3'd1, 1'b0, 32'h2001, 32'h0000_005A, 5'd1,
                   2, 32'h0);
        n_checks++;
        if (cap_mask !== 4'b0010 || cap_wdata !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL sb got %b/%h exp 0010/5a5a5a5a", cap_mask, cap_wdata);
        end
        run_access(8'h09, 1'b1, 3'd4, 1'b0, 32'h2004, 32'hDEAD_BEEF, 5'd1,
                   0, 32'h0);
        n_checks++;
        if (cap_mask !== 4'b1111 || cap_wdata !== 32'hDEAD_BEEF ||
            cap_addr !== 32'h2004) begin
            n_fail++;
            $display("FAIL sw got %b/%h/%h exp 1111/deadbeef/00002004",
                     cap_mask, cap_wdata, cap_addr);
        end
    endtask

    task automatic test_misaligned;
        i_tag         = 8'h0A;
        i_mem_read    = 1'b1;
        i_mem_write   = 1'b0;
        i_mem_width   = 3'd4;
        i_mem_signed  = 1'b0;
        i_mem_address = 32'h3001;
        i_mem_inst_rd = 5'd3;
        @(negedge clk);
`ifdef CPU_MEMORY_UNALIGNED_EN
        n_checks++;
        if (o_bus_request !== 1'b1 || o_bus_address !== 32'h3000) begin
            n_fail++;
            $display("FAIL mis_lo got %b/%h exp 1/00003000",
                     o_bus_request, o_bus_address);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h4433_2211;
        @(negedge clk);
        i_bus_ready = 1'b0;
        n_checks++;
        if (o_bus_request !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_gap got %b/%b exp 0/1", o_bus_request, o_busy);
        end
        @(negedge clk);
        n_checks++;
        if (o_bus_request !== 1'b1 || o_bus_address !== 32'h3004) begin
            n_fail++;
            $display("FAIL mis_hi got %b/%h exp 1/00003004",
                     o_bus_request, o_bus_address);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h8877_6655;
        @(negedge clk);
        i_bus_ready = 1'b0;
        n_checks++;
        if (o_rd !== 32'h5544_3322 || o_fault !== 1'b0 || o_inst_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL mis_res got %h/%b/%0d exp 55443322/0/3",
                     o_rd, o_fault, o_inst_rd);
        end
`else
        n_checks++;
        if (o_bus_request !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_noreq got %b/%b exp 0/0", o_bus_request, o_busy);
        end
        n_checks++;
        if (o_fault !== 1'b1 || o_inst_rd !== 5'd0 || o_tag !== 8'h0A) begin
            n_fail++;
            $display("FAIL mis_fault got %b/%0d/%h exp 1/0/0a",
                     o_fault, o_inst_rd, o_tag);
        end
        n_checks++;
        if (o_rd !== 32'h8000_0001) begin
            n_fail++; $display("FAIL mis_rd got %h exp 80000001", o_rd);
        end
`endif
        drive_pass(8'h0B, 32'h55, 5'd1);
        @(negedge clk);
        n_checks++;
        if (o_fault !== 1'b0 || o_rd !== 32'h55) begin
            n_fail++;
            $display("FAIL fault_clr got %b/%h exp 0/00000055", o_fault, o_rd);
        end
    endtask

    task automatic test_busy_ignore;
        i_tag         = 8'h0C;
        i_mem_read    = 1'b1;
        i_mem_width   = 3'd4;
        i_mem_address = 32'h1008;
        i_mem_inst_rd = 5'd4;
        @(negedge clk);
        drive_pass(8'h0D, 32'h777, 5'd6);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL bi_busy got %b exp 1", o_busy);
        end
        @(negedge clk);
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h1122_3344;
        @(negedge clk);
        i_bus_ready = 1'b0;
        n_checks++;
        if (o_tag !== 8'h0C || o_rd !== 32'h1122_3344 || o_inst_rd !== 5'd4) begin
            n_fail++;
            $display("FAIL bi_first got %h/%h/%0d exp 0c/11223344/4",
                     o_tag, o_rd, o_inst_rd);
        end
        @(negedge clk);
        n_checks++;
        if (o_tag !== 8'h0D || o_rd !== 32'h777 || o_inst_rd !== 5'd6) begin
            n_fail++;
            $display("FAIL bi_next got %h/%h/%0d exp 0d/00000777/6",
                     o_tag, o_rd, o_inst_rd);
        end
    endtask

    task automatic test_reset_mid;
        i_tag         = 8'h0E;
        i_mem_read    = 1'b1;
        i_mem_width   = 3'd4;
        i_mem_address = 32'h100C;
        i_mem_inst_rd = 5'd2;
        @(negedge clk);
        n_checks++;
        if (o_bus_request !== 1'b1) begin
            n_fail++; $display("FAIL rm_req got %b exp 1", o_bus_request);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_bus_request !== 1'b0 || o_tag !== 8'h00 || o_busy !== 1'b0 ||
            o_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_state got %b/%h/%b/%h exp 0/00/0/0",
                     o_bus_request, o_tag, o_busy, o_rd);
        end
        drive_pass(8'h40, 32'hCAFE, 5'd2);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_tag !== 8'h40 || o_rd !== 32'hCAFE || o_inst_rd !== 5'd2) begin
            n_fail++;
            $display("FAIL rm_after got %h/%h/%0d exp 40/0000cafe/2",
                     o_tag, o_rd, o_inst_rd);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        i_tag         = 8'h00;
        i_inst_rd     = 5'd0;
        i_mem_inst_rd = 5'd0;
        i_rd          = 32'h0;
        i_branch      = 1'b0;
        i_pc_next     = 32'h0;
        i_mem_read    = 1'b0;
        i_mem_write   = 1'b0;
        i_mem_width   = 3'd4;
        i_mem_signed  = 1'b0;
        i_mem_address = 32'h0;
        i_bus_ready   = 1'b0;
        i_bus_rdata   = 32'h0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_pass_through;
        test_loads;
        test_stores;
        test_misaligned;
        test_busy_ignore;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
